// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register-file writeback arbiter and its scoreboard.
package regfile_pkg;

  localparam int DEF_NREG       = 32;
  localparam int DEF_AW         = 5;
  localparam int DEF_DW         = 32;
  localparam int DEF_STARVE_MAX = 4;

  // MEM_PRI: loads win ties. ALU_PRI: the ALU has lost too often and wins the next tie.
  typedef enum logic {
    MEM_PRI = 1'b0,
    ALU_PRI = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at writeback,
// with a bypassed lookup for the two decode read ports.
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [NREG-1:0] busy;

  // NOTE: busy is a flop vector, not a RAM, so it can and must be reset to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      // NOTE: the later non-blocking write to the same bit wins, which gives set priority.
      if (set_en && (set_addr != '0)) busy[set_addr] <= 1'b1;
    end
  end

  // The register file forwards the data being written this cycle, so that write does not stall.
  assign rs1_busy = (rs1_addr != '0) && busy[rs1_addr] && !(clr_en && (clr_addr == rs1_addr));
  assign rs2_busy = (rs2_addr != '0) && busy[rs2_addr] && !(clr_en && (clr_addr == rs2_addr));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writeback.
// Define WB_SCOREBOARD_EN to add the pending-write scoreboard that drives rs1_busy/rs2_busy.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREG       = DEF_NREG,
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] rs1Addr,
  input  logic [AW-1:0] rs2Addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          RegWrite,
  output logic [AW-1:0] WriteAddr,
  output logic [DW-1:0] WriteData
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t    state;
  logic [CW-1:0] starve_cnt;
  logic          alu_grant;
  logic          mem_grant;

  // NOTE: grants are pure functions of current inputs and state, each assigned on every path, so no latch.
  always_comb begin
    alu_grant = alu_valid && (!mem_valid || (state == ALU_PRI));
    mem_grant = mem_valid && !alu_grant;
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MEM_PRI;
      starve_cnt <= '0;
      RegWrite   <= 1'b0;
      WriteAddr  <= '0;
      WriteData  <= '0;
    end else begin
      if (alu_grant) begin
        state      <= MEM_PRI;
        starve_cnt <= '0;
      end else if ((state == MEM_PRI) && alu_valid && mem_valid) begin
        starve_cnt <= starve_cnt + 1'b1;
        if (starve_cnt == CW'(STARVE_MAX - 1)) state <= ALU_PRI;
      end

      // x0 writes are accepted and retired without touching the register file.
      RegWrite <= 1'b0;
      if (alu_grant) begin
        RegWrite  <= (alu_addr != '0);
        WriteAddr <= alu_addr;
        WriteData <= alu_data;
      end else if (mem_grant) begin
        RegWrite  <= (mem_addr != '0);
        WriteAddr <= mem_addr;
        WriteData <= mem_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_valid),
    .set_addr (issue_rd),
    .clr_en   (RegWrite),
    .clr_addr (WriteAddr),
    .rs1_addr (rs1Addr),
    .rs2_addr (rs2Addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );
`else
  // Without the scoreboard decode never stalls; the issue/read inputs are deliberately dropped.
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{issue_valid, issue_rd, rs1Addr, rs2Addr, 32'(NREG)};
  assign rs1_busy = 1'b0;
  assign rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a loss-counting reference model.
module tb_regfile_wb_arbiter;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int STARVE = 4;
`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          iv;
    logic [AW-1:0] ird;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
  } stim_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, issue_valid;
  logic [AW-1:0] alu_addr, mem_addr, issue_rd, rs1Addr, rs2Addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, rs1_busy, rs2_busy, RegWrite;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1Addr     (rs1Addr),
    .rs2Addr     (rs2Addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .RegWrite    (RegWrite),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: pending-write set, count of ALU losses, last write-port contents.
  bit [31:0]     busy_m;
  int            losses;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          exp_alu_g, exp_mem_g;
  logic          obs_alu_r, obs_mem_r, obs_rs1, obs_rs2;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] r);
    return SB && (r != 0) && busy_m[r] && !(m_we && (m_addr == r));
  endfunction

  function automatic logic [AW-1:0] rand_reg();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic reset_model();
    busy_m = '0;
    losses = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic drive(input stim_t s);
    alu_valid   = s.av;  alu_addr = s.aa;  alu_data = s.ad;
    mem_valid   = s.mv;  mem_addr = s.ma;  mem_data = s.md;
    issue_valid = s.iv;  issue_rd = s.ird;
    rs1Addr     = s.r1;  rs2Addr  = s.r2;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered outputs after the edge.
  task automatic step(input stim_t s);
    @(negedge clk);
    drive(s);
    #1;
    exp_alu_g = s.av && (!s.mv || (losses >= STARVE));
    exp_mem_g = s.mv && !exp_alu_g;
    obs_alu_r = alu_ready;  obs_mem_r = mem_ready;
    obs_rs1   = rs1_busy;   obs_rs2   = rs2_busy;
    check("alu_ready", alu_ready, exp_alu_g);
    check("mem_ready", mem_ready, exp_mem_g);
    check("one_ready", alu_ready & mem_ready, 1'b0);
    check("rs1_busy", rs1_busy, exp_busy(s.r1));
    check("rs2_busy", rs2_busy, exp_busy(s.r2));
    @(posedge clk);
    #1;
    if (m_we) busy_m[m_addr] = 1'b0;
    if (s.iv && (s.ird != 0)) busy_m[s.ird] = 1'b1;
    if (exp_alu_g) losses = 0;
    else if (s.av && s.mv) losses++;
    m_we = 1'b0;
    if (exp_alu_g) begin
      m_we = (s.aa != 0); m_addr = s.aa; m_data = s.ad;
    end else if (exp_mem_g) begin
      m_we = (s.ma != 0); m_addr = s.ma; m_data = s.md;
    end
    check("RegWrite", RegWrite, m_we);
    check("WriteAddr", WriteAddr, m_addr);
    check("WriteData", WriteData, m_data);
  endtask

  // Assert reset away from any clock edge and confirm outputs clear without waiting for a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_we"}, RegWrite, 1'b0);
    check({tag, "_addr"}, WriteAddr, '0);
    check({tag, "_data"}, WriteData, '0);
    check({tag, "_rs1"}, rs1_busy, 1'b0);
    check({tag, "_rs2"}, rs2_busy, 1'b0);
    drive(idle());
    reset_model();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    stim_t s;
    logic          a_pend, m_pend;
    logic [AW-1:0] a_addr, m_addr_r;
    logic [DW-1:0] a_data, m_data_r;

    rst = 1'b1;
    drive(idle());
    reset_model();
    repeat (2) @(negedge clk);
    check("rst_we", RegWrite, 1'b0);
    check("rst_addr", WriteAddr, '0);
    check("rst_data", WriteData, '0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    rst = 1'b0;

    // Single ALU write, one-cycle latency, one cycle wide.
    s = idle(); s.av = 1'b1; s.aa = 5'd5; s.ad = 32'hDEADBEEF;
    step(s);
    check("single_ready", obs_alu_r, 1'b1);
    check("single_we", RegWrite, 1'b1);
    check("single_addr", WriteAddr, 5'd5);
    check("single_data", WriteData, 32'hDEADBEEF);
    step(idle());
    check("single_we_drop", RegWrite, 1'b0);
    check("single_data_hold", WriteData, 32'hDEADBEEF);

    // Contention: MEM wins STARVE cycles, then the ALU is forced through.
    for (int i = 0; i <= STARVE; i++) begin
      s = idle();
      s.av = 1'b1; s.aa = 5'd7; s.ad = 32'hA0A0_0000;
      s.mv = 1'b1; s.ma = 5'd3; s.md = 32'h0000_0300 + i;
      step(s);
      check($sformatf("cont_alu_%0d", i), obs_alu_r, (i == STARVE));
      check($sformatf("cont_mem_%0d", i), obs_mem_r, (i != STARVE));
    end
    check("cont_alu_addr", WriteAddr, 5'd7);
    s = idle(); s.av = 1'b1; s.aa = 5'd7; s.mv = 1'b1; s.ma = 5'd3;
    step(s);
    check("cont_count_reset", obs_mem_r, 1'b1);
    s.mv = 1'b0;
    step(s);

    // x0 write is accepted but never reaches the register file.
    s = idle(); s.mv = 1'b1; s.ma = 5'd0; s.md = 32'h1234_5678;
    step(s);
    check("x0_ready", obs_mem_r, 1'b1);
    check("x0_we", RegWrite, 1'b0);
    check("x0_rs1", obs_rs1, 1'b0);

    // Scoreboard: set, bypass on the writeback cycle, set beating clear on the same edge.
    s = idle(); s.iv = 1'b1; s.ird = 5'd9;
    step(s);
    s = idle(); s.r1 = 5'd9; s.av = 1'b1; s.aa = 5'd9; s.ad = 32'h99;
    step(s);
    check("sb_set", obs_rs1, SB);
    s = idle(); s.r1 = 5'd9; s.iv = 1'b1; s.ird = 5'd9;
    step(s);
    check("sb_bypass", obs_rs1, 1'b0);
    s = idle(); s.r1 = 5'd9; s.r2 = 5'd9; s.av = 1'b1; s.aa = 5'd9; s.ad = 32'h999;
    step(s);
    check("sb_set_wins", obs_rs1, SB);
    check("sb_set_wins_rs2", obs_rs2, SB);
    s = idle(); s.r1 = 5'd9;
    step(s);
    step(s);
    check("sb_cleared", obs_rs1, 1'b0);

    // Reset in the middle of traffic with a busy register and a write in flight.
    s = idle(); s.iv = 1'b1; s.ird = 5'd9; s.av = 1'b1; s.aa = 5'd12; s.ad = 32'hC0FFEE;
    step(s);
    s = idle(); s.r1 = 5'd9; s.av = 1'b1; s.aa = 5'd13;
    step(s);
    check("pre_rst_busy", obs_rs1, SB);
    check("pre_rst_we", RegWrite, 1'b1);
    async_reset("mid_rst");

    // Random traffic; requesters hold their request until it is accepted.
    a_pend = 1'b0; m_pend = 1'b0;
    a_addr = '0; a_data = '0; m_addr_r = '0; m_data_r = '0;
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        async_reset("rand_rst");
        a_pend = 1'b0;
        m_pend = 1'b0;
      end
      if (!a_pend && ($urandom_range(0, 2) != 0)) begin
        a_pend = 1'b1; a_addr = rand_reg(); a_data = $urandom;
      end
      if (!m_pend && ($urandom_range(0, 3) != 0)) begin
        m_pend = 1'b1; m_addr_r = rand_reg(); m_data_r = $urandom;
      end
      s = idle();
      s.av = a_pend; s.aa = a_addr;   s.ad = a_data;
      s.mv = m_pend; s.ma = m_addr_r; s.md = m_data_r;
      s.iv = ($urandom_range(0, 2) == 0); s.ird = rand_reg();
      s.r1 = rand_reg(); s.r2 = rand_reg();
      step(s);
      if (exp_alu_g) a_pend = 1'b0;
      if (exp_mem_g) m_pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
